// File: rtl/cpu_pkg.sv
// Shared fetch-side constants, error codes and fetch FSM state type.
package cpu_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;

  localparam logic [3:0] FERR_NONE     = 4'h0;
  localparam logic [3:0] FERR_MISALIGN = 4'h1;
  localparam logic [3:0] FERR_OVERFLOW = 4'h2;

  typedef enum logic [0:0] {
    FS_RUN   = 1'b0,
    FS_DRAIN = 1'b1
  } fetch_state_e;

  // Instruction fetches are word aligned; low address bits are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; head entry is visible on head_data.
module fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty     = (cnt_q == '0);
  assign full      = (cnt_q == (AW+1)'(DEPTH));
  assign count     = cnt_q;
  assign head_data = mem_q[rptr_q];
  assign do_pop    = pop && !empty;
  // A push into a full FIFO is accepted only when the head leaves the same cycle.
  assign do_push   = push && (!full || do_pop);

  // Next pointer/count/storage state; flush discards all entries.
  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wptr_q] = push_data;
        wptr_d        = wptr_q + AW'(1);
      end
      if (do_pop) begin
        rptr_d = rptr_q + AW'(1);
      end
      cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage needs no reset; validity is tracked by the count.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues credit-limited
// requests, buffers in-order responses with their PCs and handles redirects.
//
// state    | meaning
// FS_RUN   | normal fetch: issue requests, buffer responses
// FS_DRAIN | after a redirect: discard drop_cnt stale responses, no requests
module if_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int unsigned BUF_DEPTH = 2,
  parameter logic [31:0] NOP_INST  = NOP_INST_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_wen,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_is,
  output logic [3:0]  fetch_err
);

  localparam int unsigned CW = $clog2(BUF_DEPTH) + 1;

  fetch_state_e  state_q, state_d;
  logic [31:0]   fpc_q, fpc_d;
  logic [31:0]   last_pc_q, last_pc_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [3:0]    err_q, err_d;

  logic [CW:0]   credit_use;
  logic [CW:0]   in_flight;
  logic          req_fire, resp_ok, resp_bad, run_no_redir;

  logic          buf_push, buf_pop, buf_empty, buf_full;
  logic [63:0]   buf_head;
  logic [CW-1:0] buf_count;
  logic          pcq_push, pcq_pop, pcq_empty, pcq_full;
  logic [31:0]   pcq_head;
  logic [CW-1:0] pcq_count;
  logic          unused_fifo;

  assign credit_use = {1'b0, out_q} + {1'b0, buf_count};
  assign in_flight  = {1'b0, out_q} + {1'b0, drop_q};

  // Requests are held off while in reset so nothing is accepted that reset would orphan.
  assign imem_req_valid = !rst && (state_q == FS_RUN) && !redirect_valid
                          && (credit_use < (CW+1)'(BUF_DEPTH));
  assign imem_req_addr  = fpc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign resp_ok        = imem_resp_valid && (in_flight != '0);
  assign resp_bad       = imem_resp_valid && (in_flight == '0);
  assign run_no_redir   = !redirect_valid && (state_q == FS_RUN);

  assign pcq_push = !redirect_valid && req_fire;
  assign pcq_pop  = run_no_redir && resp_ok;
  assign buf_push = run_no_redir && resp_ok;
  assign buf_pop  = !redirect_valid && if_valid && pc_wen;

  assign if_valid  = !buf_empty;
  assign if_pc     = buf_empty ? last_pc_q : buf_head[63:32];
  assign if_is     = buf_empty ? NOP_INST : buf_head[31:0];
  assign fetch_err = err_q;

  assign unused_fifo = ^{buf_full, pcq_empty, pcq_full, pcq_count};

  fetch_fifo #(.WIDTH(64), .DEPTH(BUF_DEPTH)) u_inst_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (buf_push),
    .push_data ({pcq_head, imem_resp_data}),
    .pop       (buf_pop),
    .head_data (buf_head),
    .empty     (buf_empty),
    .full      (buf_full),
    .count     (buf_count)
  );

  fetch_fifo #(.WIDTH(32), .DEPTH(BUF_DEPTH)) u_pc_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (pcq_push),
    .push_data (fpc_q),
    .pop       (pcq_pop),
    .head_data (pcq_head),
    .empty     (pcq_empty),
    .full      (pcq_full),
    .count     (pcq_count)
  );

  // Fetch PC, credit counters, drain tracking and sticky error update.
  always_comb begin
    state_d   = state_q;
    fpc_d     = fpc_q;
    out_d     = out_q;
    drop_d    = drop_q;
    err_d     = err_q;
    last_pc_d = buf_empty ? last_pc_q : buf_head[63:32];

    // First error wins; a misaligned redirect outranks a same-cycle overflow.
    if (err_q == FERR_NONE) begin
      if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
        err_d = FERR_MISALIGN;
      end else if (resp_bad) begin
        err_d = FERR_OVERFLOW;
      end
    end

    if (redirect_valid) begin
      fpc_d   = word_align(redirect_pc);
      out_d   = '0;
      // Everything still in flight after this edge belongs to the old path.
      drop_d  = CW'(in_flight + (CW+1)'(req_fire) - (CW+1)'(resp_ok));
      state_d = (drop_d != '0) ? FS_DRAIN : FS_RUN;
    end else if (state_q == FS_RUN) begin
      if (req_fire) begin
        fpc_d = fpc_q + 32'd4;
      end
      out_d = out_q + CW'(req_fire) - CW'(resp_ok);
    end else begin
      if (resp_ok) begin
        drop_d = drop_q - CW'(1);
      end
      if (drop_d == '0) begin
        state_d = FS_RUN;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FS_RUN;
      fpc_q     <= RESET_PC;
      last_pc_q <= RESET_PC;
      out_q     <= '0;
      drop_q    <= '0;
      err_q     <= FERR_NONE;
    end else begin
      state_q   <= state_d;
      fpc_q     <= fpc_d;
      last_pc_q <= last_pc_d;
      out_q     <= out_d;
      drop_q    <= drop_d;
      err_q     <= err_d;
    end
  end

endmodule
